// File: rtl/uart_rx_ip.sv
// Memory-mapped 8N1 UART receiver with RX FIFO, sticky error flags and level interrupt.
// state       | meaning
// S_IDLE      | line idle, waiting for a falling edge on rxs
// S_START     | timing to mid start bit to reject glitches
// S_DATA      | sampling 8 data bits LSB first, one per DIV clocks
// S_STOP      | sampling the stop bit
// S_WAIT_IDLE | framing error seen, waiting for line to return high
module uart_rx_ip #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        sel,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        i_rxd,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t      state;
  logic        rx_meta, rxs;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        push_q;
  logic [7:0]  push_byte;
  logic        ferr_set;

  logic        ctrl_en, ctrl_irq_en;
  logic [15:0] div_reg;
  logic        overrun, frame_err;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        wr_acc, rd_acc, pop, full, not_empty, do_push;
  logic [15:0] half_pt, last_pt;
  logic [3:0]  cnt4;
  logic        wdata_unused;

  assign wr_acc    = sel & wr_en & ~rd_en;
  assign rd_acc    = sel & rd_en;
  assign not_empty = (count != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = rd_acc && (addr == 2'b00) && not_empty;
  // a push into a full FIFO is still accepted when a pop frees a slot that cycle
  assign do_push   = push_q && (!full || pop);
  assign half_pt   = div_reg >> 1;
  assign last_pt   = div_reg - 16'd1;
  assign cnt4      = 4'(count);
  assign irq_o     = ctrl_irq_en & not_empty;
  assign wdata_unused = ^wdata[31:16];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_q    <= 1'b0;
      push_byte <= '0;
      ferr_set  <= 1'b0;
    end else begin
      push_q   <= 1'b0;
      ferr_set <= 1'b0;
      if (!ctrl_en) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (!rxs) begin
              state   <= S_START;
              bit_cnt <= '0;
            end
          end
          S_START: begin
            if (bit_cnt >= half_pt) begin
              bit_cnt <= '0;
              bit_idx <= '0;
              state   <= rxs ? S_IDLE : S_DATA;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          S_DATA: begin
            if (bit_cnt >= last_pt) begin
              bit_cnt        <= '0;
              shift[bit_idx] <= rxs;
              if (bit_idx == 3'd7) state <= S_STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          S_STOP: begin
            if (bit_cnt >= last_pt) begin
              bit_cnt <= '0;
              if (rxs) begin
                push_q    <= 1'b1;
                push_byte <= shift;
                state     <= S_IDLE;
              end else begin
                ferr_set <= 1'b1;
                state    <= S_WAIT_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end
          S_WAIT_IDLE: begin
            if (rxs) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      div_reg     <= DIV_RST;
      rdata       <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // set events take priority over a software clear in the same cycle
      if (push_q && full && !pop)                     overrun <= 1'b1;
      else if (wr_acc && addr == 2'b01 && wdata[2])   overrun <= 1'b0;
      if (ferr_set)                                   frame_err <= 1'b1;
      else if (wr_acc && addr == 2'b01 && wdata[3])   frame_err <= 1'b0;

      if (wr_acc && addr == 2'b10) begin
        ctrl_en     <= wdata[0];
        ctrl_irq_en <= wdata[1];
      end
      if (wr_acc && addr == 2'b11)
        div_reg <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];

      if (rd_acc) begin
        unique case (addr)
          2'b00: rdata <= {24'b0, not_empty ? mem[rd_ptr] : 8'h00};
          2'b01: rdata <= {24'b0, cnt4, frame_err, overrun, full, not_empty};
          2'b10: rdata <= {30'b0, ctrl_irq_en, ctrl_en};
          default: rdata <= {16'b0, div_reg};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ip.sv
// Randomised scoreboard bench for uart_rx_ip: expected register reads come from a
// byte-queue model of the receiver; a monitor compares each registered read.
`timescale 1ns/1ps
module tb_uart_rx_ip;
  localparam int BIT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rxd = 1'b1;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_ip #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .sel(sel), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .i_rxd(rxd), .irq_o(irq)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;
  logic [31:0] mon_exp;
  string       mon_name;

  // model state
  logic [7:0] mq[$];
  bit m_ovr = 0, m_ferr = 0, m_en = 0, m_irq = 0;
  int m_div = 10;

  always @(posedge clk) rd_seen <= sel & rd_en;

  always @(negedge clk) begin
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h exp=none", rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (rdata !== mon_exp) begin
          errors++;
          $display("FAIL %s got=%h exp=%h", mon_name, rdata, mon_exp);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int sz = mq.size();
    logic [3:0] c = 4'(sz);
    return {24'b0, c, m_ferr, m_ovr, (sz == 4), (sz != 0)};
  endfunction

  function automatic logic [31:0] m_expect(input logic [1:0] a);
    logic [31:0] e;
    case (a)
      2'b00: e = (mq.size() != 0) ? {24'b0, mq.pop_front()} : 32'h0;
      2'b01: e = m_status();
      2'b10: e = {30'b0, m_irq, m_en};
      default: e = 32'(m_div);
    endcase
    return e;
  endfunction

  task automatic model_rx(input logic [7:0] b, input bit stop_ok);
    if (!m_en) return;
    if (!stop_ok) m_ferr = 1;
    else if (mq.size() < 4) mq.push_back(b);
    else m_ovr = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1; wr_en = 1; addr = a; wdata = d;
    case (a)
      2'b01: begin if (d[2]) m_ovr = 0; if (d[3]) m_ferr = 0; end
      2'b10: begin m_en = d[0]; m_irq = d[1]; end
      2'b11: m_div = (d[15:0] < 16'd4) ? 4 : int'(d[15:0]);
      default: ;
    endcase
    @(negedge clk);
    sel = 0; wr_en = 0;
  endtask

  task automatic reg_read(input logic [1:0] a, input string n);
    @(negedge clk);
    exp_q.push_back(m_expect(a));
    name_q.push_back(n);
    sel = 1; rd_en = 1; addr = a;
    @(negedge clk);
    sel = 0; rd_en = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_v, input int stop_len);
    @(negedge clk);
    rxd = 0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_v;
    repeat (stop_len) @(negedge clk);
    rxd = 1;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog timeout got=running exp=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bit fdone;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst = 0;
    reg_read(2'b01, "reset_status");
    reg_read(2'b10, "reset_ctrl");
    reg_read(2'b11, "reset_div");

    reg_write(2'b11, 32'h2);
    reg_read(2'b11, "div_clamp");
    reg_write(2'b11, 32'hABCD_1234);
    reg_read(2'b11, "div_wide");
    reg_write(2'b11, 32'd10);

    // simultaneous read and write: read happens, write ignored
    @(negedge clk);
    exp_q.push_back(m_expect(2'b10)); name_q.push_back("rdwr_read");
    sel = 1; rd_en = 1; wr_en = 1; addr = 2'b10; wdata = 32'h3;
    @(negedge clk);
    sel = 0; rd_en = 0; wr_en = 0;
    reg_read(2'b10, "rdwr_ctrl_kept");
    reg_write(2'b00, 32'hFF);
    reg_read(2'b00, "empty_data");

    reg_write(2'b10, 32'h1);
    send_frame(8'hA5, 1, BIT); model_rx(8'hA5, 1); idle(3);
    reg_read(2'b01, "a5_status");
    reg_read(2'b00, "a5_data");
    reg_read(2'b01, "a5_status_after");

    @(negedge clk); rxd = 0; idle(3); rxd = 1; idle(20);
    reg_read(2'b01, "glitch_status");

    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1, BIT); model_rx(8'(k), 1); idle(2);
    end
    reg_read(2'b01, "ovr_status");
    for (int k = 0; k < 5; k++) reg_read(2'b00, "ovr_data");
    reg_write(2'b01, 32'h4);
    reg_read(2'b01, "ovr_cleared");

    send_frame(8'h3C, 0, 20); model_rx(8'h3C, 0); idle(5);
    reg_read(2'b01, "ferr_status");
    send_frame(8'h7E, 1, BIT); model_rx(8'h7E, 1); idle(3);
    reg_read(2'b01, "after_ferr_status");
    reg_read(2'b00, "after_ferr_data");
    reg_write(2'b01, 32'h8);
    reg_read(2'b01, "ferr_cleared");

    reg_write(2'b10, 32'h3);
    check("irq_idle", {31'b0, irq}, 32'h0);
    send_frame(8'h55, 1, 5);
    check("irq_before_push", {31'b0, irq}, 32'h0);
    idle(6); model_rx(8'h55, 1);
    check("irq_after_push", {31'b0, irq}, 32'h1);
    reg_read(2'b00, "irq_data");
    check("irq_after_pop", {31'b0, irq}, 32'h0);

    fork
      send_frame(8'h99, 1, BIT);
      begin idle(40); reg_write(2'b10, 32'h0); end
    join
    model_rx(8'h99, 1);
    idle(3);
    reg_write(2'b10, 32'h1);
    reg_read(2'b01, "disable_midframe_status");

    for (int r = 0; r < 8; r++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1, BIT); model_rx(b, 1);
      idle($urandom_range(2, 12));
      if ($urandom_range(0, 1) == 1) begin
        reg_read(2'b01, "rand_status");
        reg_read(2'b00, "rand_data");
      end
    end
    reg_read(2'b01, "rand_final_status");
    for (int k = 0; k < 4; k++) reg_read(2'b00, "rand_drain");
    reg_write(2'b01, 32'hC);
    reg_read(2'b01, "rand_cleared");

    reg_write(2'b10, 32'h3);
    send_frame(8'h11, 1, BIT); model_rx(8'h11, 1); idle(2);
    send_frame(8'h22, 1, BIT); model_rx(8'h22, 1); idle(2);
    reg_read(2'b01, "prereset_status");
    check("prereset_irq", {31'b0, irq}, 32'h1);
    fdone = 0;
    fork
      begin send_frame(8'h5A, 1, BIT); fdone = 1; end
    join_none
    idle(35);
    #2 rst = 1;
    #1;
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    mq.delete(); m_ovr = 0; m_ferr = 0; m_en = 0; m_irq = 0; m_div = 10;
    idle(2);
    rst = 0;
    wait (fdone);
    idle(5);
    reg_read(2'b01, "postreset_status");
    reg_read(2'b10, "postreset_ctrl");
    reg_read(2'b11, "postreset_div");
    reg_read(2'b00, "postreset_data");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
